// File: rtl/tmds_align_ctrl.sv
// TMDS link-training controller: per-channel bit-slip alignment, lock declaration, loss monitor.
// Optional per-channel locked error counters when TMDS_ALIGN_ERRCNT_EN is defined.
module tmds_align_ctrl #(
  parameter int unsigned WINDOW_LEN = 1024,
  parameter int unsigned SETTLE_LEN = 16,
  parameter int unsigned MAX_SLIPS  = 10,
  parameter int unsigned ERR_THRESH = 4
) (
  input  logic        clk_1x_in,
  input  logic        reset_in,
  input  logic [2:0]  error_in,
  output logic [2:0]  slip_out,
  output logic [2:0]  sync_done_out,
  output logic        link_locked_out,
  output logic        decoder_reset_out,
`ifdef TMDS_ALIGN_ERRCNT_EN
  output logic [47:0] err_count_out,
`endif
  output logic [7:0]  retrain_count_out
);

  localparam int unsigned WinW  = $clog2(WINDOW_LEN) + 1;
  localparam int unsigned SetW  = $clog2(SETTLE_LEN) + 1;
  localparam int unsigned SlipW = $clog2(MAX_SLIPS) + 1;
  localparam int unsigned ErrW  = $clog2(ERR_THRESH) + 1;

  typedef enum logic [2:0] {StSettle, StCheck, StSlip, StFail, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [SlipW-1:0] slip_cnt_q, slip_cnt_d;
  logic [SetW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d;
  logic [ErrW-1:0]  err_cnt_q, err_cnt_d;
  logic [2:0]       slip_q, slip_d;
  logic [2:0]       sync_q, sync_d;
  logic             locked_q, locked_d;
  logic             dec_rst_q, dec_rst_d;
  logic [7:0]       retrain_q, retrain_d;

  logic [2:0]       ch_oh;
  logic             err_ch;
  logic [1:0]       err_pop;
  logic [ErrW:0]    err_sum;
  logic             err_hit;
  logic             win_last;
  logic [7:0]       retrain_inc;

  always_comb begin
    ch_oh       = 3'b001 << ch_q;
    err_ch      = |(error_in & ch_oh);
    err_pop     = {1'b0, error_in[0]} + {1'b0, error_in[1]} + {1'b0, error_in[2]};
    err_sum     = (ErrW + 1)'(err_cnt_q) + (ErrW + 1)'(err_pop);
    err_hit     = err_sum >= (ErrW + 1)'(ERR_THRESH);
    win_last    = win_cnt_q == WinW'(WINDOW_LEN - 1);
    retrain_inc = (retrain_q == 8'hff) ? retrain_q : retrain_q + 8'd1;

    state_d      = state_q;
    ch_d         = ch_q;
    slip_cnt_d   = slip_cnt_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    err_cnt_d    = err_cnt_q;
    slip_d       = '0;
    sync_d       = sync_q;
    locked_d     = locked_q;
    dec_rst_d    = dec_rst_q;
    retrain_d    = retrain_q;

    unique case (state_q)
      StSettle: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == SetW'(SETTLE_LEN)) begin
          state_d      = StCheck;
          settle_cnt_d = '0;
          win_cnt_d    = '0;
        end
      end
      StCheck: begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (err_ch) begin
          if (slip_cnt_q == SlipW'(MAX_SLIPS)) begin
            state_d = StFail;
          end else begin
            state_d = StSlip;
            slip_d  = ch_oh;
          end
        end else if (win_last) begin
          sync_d     = sync_q | ch_oh;
          slip_cnt_d = '0;
          if (ch_q == 2'd2) begin
            state_d   = StLocked;
            locked_d  = 1'b1;
            dec_rst_d = 1'b0;
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            state_d = StSettle;
            ch_d    = ch_q + 2'd1;
          end
        end
      end
      StSlip: begin
        slip_cnt_d   = slip_cnt_q + 1'b1;
        settle_cnt_d = '0;
        state_d      = StSettle;
      end
      StFail: begin
        sync_d       = '0;
        ch_d         = '0;
        slip_cnt_d   = '0;
        settle_cnt_d = '0;
        retrain_d    = retrain_inc;
        state_d      = StSettle;
      end
      StLocked: begin
        // Loss wins over a same-cycle window wrap.
        if (err_hit) begin
          sync_d       = '0;
          locked_d     = 1'b0;
          dec_rst_d    = 1'b1;
          retrain_d    = retrain_inc;
          ch_d         = '0;
          slip_cnt_d   = '0;
          settle_cnt_d = '0;
          win_cnt_d    = '0;
          err_cnt_d    = '0;
          state_d      = StSettle;
        end else if (win_last) begin
          win_cnt_d = '0;
          err_cnt_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          err_cnt_d = err_sum[ErrW-1:0];
        end
      end
      default: state_d = StSettle;
    endcase
  end

  always_ff @(posedge clk_1x_in) begin
    if (reset_in) begin
      state_q      <= StSettle;
      ch_q         <= '0;
      slip_cnt_q   <= '0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      err_cnt_q    <= '0;
      slip_q       <= '0;
      sync_q       <= '0;
      locked_q     <= 1'b0;
      dec_rst_q    <= 1'b1;
      retrain_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      slip_cnt_q   <= slip_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_q       <= slip_d;
      sync_q       <= sync_d;
      locked_q     <= locked_d;
      dec_rst_q    <= dec_rst_d;
      retrain_q    <= retrain_d;
    end
  end

  assign slip_out          = slip_q;
  assign sync_done_out     = sync_q;
  assign link_locked_out   = locked_q;
  assign decoder_reset_out = dec_rst_q;
  assign retrain_count_out = retrain_q;

`ifdef TMDS_ALIGN_ERRCNT_EN
  logic [15:0] ecnt_q [3];
  logic [15:0] ecnt_d [3];

  // Counts only while locked; deliberately survives retraining.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      ecnt_d[n] = ecnt_q[n];
      if (locked_q && error_in[n] && (ecnt_q[n] != 16'hffff)) ecnt_d[n] = ecnt_q[n] + 16'd1;
    end
  end

  always_ff @(posedge clk_1x_in) begin
    for (int n = 0; n < 3; n++) begin
      if (reset_in) ecnt_q[n] <= '0;
      else          ecnt_q[n] <= ecnt_d[n];
    end
  end

  assign err_count_out = {ecnt_q[2], ecnt_q[1], ecnt_q[0]};
`endif

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Bench for tmds_align_ctrl: vector table, directed corner sequences and random traffic
// against a cycle-level behavioural model. Honours TMDS_ALIGN_ERRCNT_EN when defined.
module tb_tmds_align_ctrl;
  localparam int WL = 16;
  localparam int SL = 4;
  localparam int MS = 10;
  localparam int ET = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  err;
  logic [2:0]  slip, sync;
  logic        locked, dec_rst;
  logic [7:0]  retrain;
`ifdef TMDS_ALIGN_ERRCNT_EN
  logic [47:0] err_count;
`endif

  tmds_align_ctrl #(
    .WINDOW_LEN(WL), .SETTLE_LEN(SL), .MAX_SLIPS(MS), .ERR_THRESH(ET)
  ) dut (
    .clk_1x_in        (clk),
    .reset_in         (rst),
    .error_in         (err),
    .slip_out         (slip),
    .sync_done_out    (sync),
    .link_locked_out  (locked),
    .decoder_reset_out(dec_rst),
`ifdef TMDS_ALIGN_ERRCNT_EN
    .err_count_out    (err_count),
`endif
    .retrain_count_out(retrain)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: training is "quiet time, then WL clean cycles on the current channel".
  logic [2:0] m_sync, m_slip;
  logic       m_locked, m_fail_pend;
  int         m_retrain, m_ch, m_slips, m_quiet, m_good, m_win, m_errs;
  int         m_ecnt [3];

  task automatic model_step(input logic [2:0] e, input logic r);
    if (r) begin
      m_sync = 0; m_slip = 0; m_locked = 0; m_fail_pend = 0; m_retrain = 0;
      m_ch = 0; m_slips = 0; m_quiet = SL + 1; m_good = 0; m_win = 0; m_errs = 0;
      for (int n = 0; n < 3; n++) m_ecnt[n] = 0;
      return;
    end
    for (int n = 0; n < 3; n++) if (m_locked && e[n] && m_ecnt[n] < 65535) m_ecnt[n]++;
    m_slip = 0;
    if (m_locked) begin
      m_win++;
      m_errs += $countones(e);
      if (m_errs >= ET) begin
        m_locked = 0; m_sync = 0; m_ch = 0; m_slips = 0; m_quiet = SL + 1;
        if (m_retrain < 255) m_retrain++;
      end else if (m_win == WL) begin
        m_win = 0; m_errs = 0;
      end
    end else if (m_fail_pend) begin
      m_fail_pend = 0; m_sync = 0; m_ch = 0; m_slips = 0; m_quiet = SL + 1;
      if (m_retrain < 255) m_retrain++;
    end else if (m_quiet > 0) begin
      m_quiet--; m_good = 0;
    end else if (e[m_ch]) begin
      m_good = 0;
      if (m_slips < MS) begin
        m_slip = 3'(1 << m_ch); m_slips++; m_quiet = SL + 2;
      end else begin
        m_fail_pend = 1;
      end
    end else begin
      m_good++;
      if (m_good == WL) begin
        m_sync[m_ch] = 1'b1; m_slips = 0; m_good = 0;
        if (m_ch == 2) begin
          m_locked = 1; m_win = 0; m_errs = 0;
        end else begin
          m_ch++; m_quiet = SL + 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [2:0] e, input logic r);
    err = e;
    rst = r;
    @(posedge clk);
    model_step(e, r);
    #1;
    chk("slip_out", 64'(slip), 64'(m_slip));
    chk("sync_done_out", 64'(sync), 64'(m_sync));
    chk("link_locked_out", 64'(locked), 64'(m_locked));
    chk("decoder_reset_out", 64'(dec_rst), 64'(!m_locked));
    chk("retrain_count_out", 64'(retrain), 64'(m_retrain));
`ifdef TMDS_ALIGN_ERRCNT_EN
    chk("err_count_out", 64'(err_count), 64'({16'(m_ecnt[2]), 16'(m_ecnt[1]), 16'(m_ecnt[0])}));
`endif
  endtask

  task automatic do_reset();
    tick(3'b000, 1'b1);
    tick(3'b000, 1'b1);
  endtask

  task automatic wait_lock();
    int n = 0;
    while (!locked && n < 150) begin
      tick(3'b000, 1'b0);
      n++;
    end
    chk("lock_reached", 64'(locked), 64'd1);
  endtask

  typedef struct {
    int         edge_n;
    logic [2:0] sync;
    logic       locked;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, pulses, other, last, min_gap;
    logic [2:0] e;
    err = 0;
    rst = 1;

    // 1. Clean training timeline from reset release.
    tbl[0] = '{edge_n: 0,  sync: 3'b000, locked: 1'b0};
    tbl[1] = '{edge_n: 20, sync: 3'b000, locked: 1'b0};
    tbl[2] = '{edge_n: 21, sync: 3'b001, locked: 1'b0};
    tbl[3] = '{edge_n: 41, sync: 3'b001, locked: 1'b0};
    tbl[4] = '{edge_n: 42, sync: 3'b011, locked: 1'b0};
    tbl[5] = '{edge_n: 62, sync: 3'b011, locked: 1'b0};
    tbl[6] = '{edge_n: 63, sync: 3'b111, locked: 1'b1};
    do_reset();
    chk("reset_slip", 64'(slip), 64'd0);
    chk("reset_decoder_reset", 64'(dec_rst), 64'd1);
    chk("reset_retrain", 64'(retrain), 64'd0);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      while (n < tbl[i].edge_n) begin
        tick(3'b000, 1'b0);
        n++;
      end
      chk($sformatf("tbl%0d_sync", i), 64'(sync), 64'(tbl[i].sync));
      chk($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].locked));
    end

    // 2. Three slips on ch0, then clean.
    do_reset();
    pulses = 0; other = 0; last = -100; min_gap = 1000; n = 0;
    while (pulses < 3 && n < 200) begin
      tick(3'b001, 1'b0);
      n++;
      if (slip != 0) begin
        chk("t2_slip_ch0", 64'(slip), 64'b001);
        if (n - last < min_gap) min_gap = n - last;
        last = n;
        pulses++;
      end
    end
    n = 0;
    while (sync != 3'b111 && n < 150) begin
      tick(3'b000, 1'b0);
      n++;
      if (slip != 0) other++;
    end
    chk("t2_slip_count", 64'(pulses), 64'd3);
    chk("t2_gap_ge5", 64'(min_gap >= 5), 64'd1);
    chk("t2_no_other_slips", 64'(other), 64'd0);
    chk("t2_all_synced", 64'(sync), 64'b111);

    // 3. ch1 error stuck: ten slips then a failed attempt.
    do_reset();
    pulses = 0; other = 0; n = 0;
    while (retrain == 0 && n < 2000) begin
      tick(3'b010, 1'b0);
      n++;
      if (slip == 3'b010) pulses++;
      else if (slip != 0) other++;
    end
    chk("t3_slip_count", 64'(pulses), 64'd10);
    chk("t3_other_slips", 64'(other), 64'd0);
    chk("t3_sync_cleared", 64'(sync), 64'b000);
    chk("t3_retrain", 64'(retrain), 64'd1);
    n = 0;
    while (sync != 3'b001 && n < 40) begin
      tick(3'b000, 1'b0);
      n++;
    end
    chk("t3_restart_ch0_cycles", 64'(n), 64'd21);

    // 4. Four single errors inside one locked window.
    do_reset();
    wait_lock();
    tick(3'b001, 1'b0); tick(3'b000, 1'b0);
    tick(3'b001, 1'b0); tick(3'b000, 1'b0);
    tick(3'b001, 1'b0); tick(3'b000, 1'b0);
    chk("t4_held_after_3", 64'(locked), 64'd1);
    tick(3'b001, 1'b0);
    chk("t4_lost", 64'(locked), 64'd0);
    chk("t4_decoder_reset", 64'(dec_rst), 64'd1);
    chk("t4_retrain", 64'(retrain), 64'd1);

    // 5. Three errors per window for five windows, one on the wrap cycle.
    wait_lock();
    other = 0;
    for (int k = 0; k < 5 * WL; k++) begin
      e = (k % WL == 0 || k % WL == 7 || k % WL == WL - 1) ? 3'(1 << (k % 3)) : 3'b000;
      tick(e, 1'b0);
      if (!locked) other++;
    end
    chk("t5_lock_held", 64'(other), 64'd0);
    chk("t5_no_retrain", 64'(retrain), 64'd1);
    tick(3'b111, 1'b0);
    chk("t5_pop3_held", 64'(locked), 64'd1);
    tick(3'b001, 1'b0);
    chk("t5_pop_loss", 64'(locked), 64'd0);
    chk("t5_retrain2", 64'(retrain), 64'd2);

    // 6. Reset mid-LOCKED, then reset during a SLIP cycle.
    wait_lock();
    tick(3'b101, 1'b0);
    tick(3'b000, 1'b1);
    chk("t6_locked_rst_retrain", 64'(retrain), 64'd0);
    chk("t6_locked_rst_lock", 64'(locked), 64'd0);
    chk("t6_locked_rst_dec", 64'(dec_rst), 64'd1);
`ifdef TMDS_ALIGN_ERRCNT_EN
    chk("t6_errcnt_zero", 64'(err_count), 64'd0);
`endif
    n = 0;
    while (slip == 0 && n < 60) begin
      tick(3'b001, 1'b0);
      n++;
    end
    chk("t6_slip_seen", 64'(slip), 64'b001);
    tick(3'b001, 1'b1);
    chk("t6_slip_rst_slip", 64'(slip), 64'd0);
    chk("t6_slip_rst_sync", 64'(sync), 64'd0);

    // Random traffic at several error densities, with occasional resets.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int p;
      p = (ph == 0) ? 3 : (ph == 1) ? 15 : (ph == 2) ? 60 : 0;
      for (int k = 0; k < 1500; k++) begin
        for (int b = 0; b < 3; b++) e[b] = ($urandom_range(0, 999) < p);
        tick(e, $urandom_range(0, 1999) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
